// File: rtl/tx_scheduler_pkg.sv
// Shared types for the DCSK transmit front-end: spreading factors, scheduler states,
// and the queued request payload.
package tx_scheduler_pkg;

  localparam int unsigned MSG_W = 32;
  localparam int unsigned LEN_W = 12;
  localparam int unsigned ID_W  = 16;

  typedef enum logic [1:0] {
    SF2  = 2'd0,
    SF4  = 2'd1,
    SF8  = 2'd2,
    SF16 = 2'd3
  } sf_t;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    SEND,
    WAIT_START,
    SENDING,
    GAP
  } tx_sched_state_t;

  typedef struct packed {
    logic [MSG_W-1:0] msg;
    sf_t              sf;
  } tx_req_t;

  // Expected frame length in cycles: 64 << (sf+1).
  function automatic logic [LEN_W-1:0] frame_len(input sf_t sf);
    return LEN_W'(128) << sf;
  endfunction

endpackage

// File: rtl/tx_scheduler_sync_fifo.sv
// Single-clock FIFO with occupancy count; push/pop are ignored when full/empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (o_level == LW'(DEPTH));
  assign o_empty = (o_level == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      o_level <= o_level + LW'(1);
      else if (do_pop && !do_push) o_level <= o_level - LW'(1);
    end
  end

  // Storage needs no reset: a slot is always written before it is read.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/tx_scheduler.sv
// Queues messages for the DCSK transmitter, loads seeds between frames, and polices
// frame start and frame length.
module tx_scheduler
  import tx_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned GAP_CYCLES    = 0,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                            i_clk,
  input  logic                            i_arst_n,
  input  logic                            i_msg_valid,
  output logic                            o_msg_ready,
  input  logic [MSG_W-1:0]                i_msg,
  input  sf_t                             i_sf,
  input  logic                            i_seed_valid,
  input  logic [MSG_W-1:0]                i_seed,
  output logic [MSG_W-1:0]                o_tx_seed,
  output logic                            o_tx_load_seed,
  output logic                            o_tx_send,
  output logic [MSG_W-1:0]                o_tx_msg,
  output sf_t                             o_tx_sf,
  input  logic                            i_tx_is_sending,
  output logic                            o_busy,
  output logic [$clog2(FIFO_DEPTH):0]     o_level,
  output logic                            o_frame_done,
  output logic                            o_err_len,
  output logic                            o_err_timeout,
  output logic [ID_W-1:0]                 o_msg_id
);

  localparam int unsigned TMR_W = $clog2(START_TIMEOUT + 2);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);

  tx_sched_state_t  state;
  logic             seed_pend;
  logic [MSG_W-1:0] seed_q;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic [LEN_W-1:0] len_cnt;
  tx_req_t          push_req;
  tx_req_t          head;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign push_req    = '{msg: i_msg, sf: i_sf};
  assign pop         = (state == IDLE) && !seed_pend && !fifo_empty;
  assign o_msg_ready = !fifo_full;
  assign o_busy      = (state != IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH ($bits(tx_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_push   (i_msg_valid),
    .i_data   (push_req),
    .i_pop    (pop),
    .o_data   (head),
    .o_level  (o_level),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty)
  );

  // Seed request latch; a request in the SEED cycle itself stays pending (last wins).
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      seed_pend <= 1'b0;
      seed_q    <= '0;
    end else if (i_seed_valid) begin
      seed_pend <= 1'b1;
      seed_q    <= i_seed;
    end else if (state == SEED) begin
      seed_pend <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state          <= IDLE;
      timer          <= '0;
      gap_cnt        <= '0;
      len_cnt        <= '0;
      o_tx_seed      <= '0;
      o_tx_load_seed <= 1'b0;
      o_tx_send      <= 1'b0;
      o_tx_msg       <= '0;
      o_tx_sf        <= SF2;
      o_frame_done   <= 1'b0;
      o_err_len      <= 1'b0;
      o_err_timeout  <= 1'b0;
      o_msg_id       <= '0;
    end else begin
      o_tx_load_seed <= 1'b0;
      o_tx_send      <= 1'b0;
      o_frame_done   <= 1'b0;
      o_err_len      <= 1'b0;
      o_err_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_pend) begin
            state <= SEED;
          end else if (!fifo_empty) begin
            o_tx_msg <= head.msg;
            o_tx_sf  <= head.sf;
            state    <= SEND;
          end
        end
        SEED: begin
          o_tx_seed      <= seed_q;
          o_tx_load_seed <= 1'b1;
          state          <= IDLE;
        end
        SEND: begin
          o_tx_send <= 1'b1;
          timer     <= '0;
          state     <= WAIT_START;
        end
        WAIT_START: begin
          if (i_tx_is_sending) begin
            len_cnt <= LEN_W'(1);
            state   <= SENDING;
          end else if (timer == TMR_W'(START_TIMEOUT)) begin
            o_err_timeout <= 1'b1;
            gap_cnt       <= '0;
            state         <= GAP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        SENDING: begin
          if (i_tx_is_sending) begin
            if (len_cnt != '1) len_cnt <= len_cnt + LEN_W'(1);
          end else begin
            o_frame_done <= 1'b1;
            o_msg_id     <= o_msg_id + ID_W'(1);
            if (len_cnt != frame_len(o_tx_sf)) o_err_len <= 1'b1;
            gap_cnt      <= '0;
            state        <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt >= GAP_W'(GAP_CYCLES)) state <= IDLE;
          else                               gap_cnt <= gap_cnt + GAP_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler with a behavioural tx stub driving i_tx_is_sending.
module tb_tx_scheduler;
  import tx_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [31:0] msg = '0;
  sf_t         sf = SF2;
  logic        seed_valid = 1'b0;
  logic [31:0] seed = '0;
  logic [31:0] tx_seed;
  logic        load_seed;
  logic        tx_send;
  logic [31:0] tx_msg;
  sf_t         tx_sf;
  logic        is_sending;
  logic        busy;
  logic [2:0]  level;
  logic        frame_done;
  logic        err_len;
  logic        err_timeout;
  logic [15:0] msg_id;

  tx_scheduler #(.FIFO_DEPTH(4), .GAP_CYCLES(0), .START_TIMEOUT(4)) dut (
    .i_clk(clk), .i_arst_n(rst_n), .i_msg_valid(msg_valid), .o_msg_ready(msg_ready),
    .i_msg(msg), .i_sf(sf), .i_seed_valid(seed_valid), .i_seed(seed),
    .o_tx_seed(tx_seed), .o_tx_load_seed(load_seed), .o_tx_send(tx_send),
    .o_tx_msg(tx_msg), .o_tx_sf(tx_sf), .i_tx_is_sending(is_sending), .o_busy(busy),
    .o_level(level), .o_frame_done(frame_done), .o_err_len(err_len),
    .o_err_timeout(err_timeout), .o_msg_id(msg_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int stub_len = 128;   // 0: never start, -1: nominal length for the sf, else cycles
  int push_cyc;

  logic [31:0] send_msg_q[$];
  sf_t         send_sf_q[$];
  int          send_cyc_q[$];
  int          fd_cyc_q[$];
  int          to_cyc_q[$];
  logic [31:0] seed_val_q[$];
  int          seed_cyc_q[$];
  int          elen_cnt = 0;
  int          elen_orphan = 0;

  // Event recorder, sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tx_send) begin
        send_msg_q.push_back(tx_msg); send_sf_q.push_back(tx_sf); send_cyc_q.push_back(cyc);
      end
      if (frame_done) fd_cyc_q.push_back(cyc);
      if (err_len) begin elen_cnt++; if (!frame_done) elen_orphan++; end
      if (err_timeout) to_cyc_q.push_back(cyc);
      if (load_seed) begin seed_val_q.push_back(tx_seed); seed_cyc_q.push_back(cyc); end
    end
  end

  // tx stub: one cycle after the send pulse, hold is_sending for n cycles.
  initial begin : stub
    int n;
    is_sending = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_send && stub_len != 0) begin
        n = (stub_len < 0) ? (128 << int'(tx_sf)) : stub_len;
        @(posedge clk); #1; is_sending = 1'b1;
        repeat (n) @(posedge clk);
        #1; is_sending = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 3000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] m, input sf_t s, output bit acc);
    @(negedge clk);
    acc = msg_ready;
    msg_valid = 1'b1; msg = m; sf = s;
    @(posedge clk); #1;
    push_cyc = cyc;
    msg_valid = 1'b0;
  endtask

  task automatic wait_events(input int target, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fd_cyc_q.size() + to_cyc_q.size() >= target) break;
    end
    if (i == budget) begin
      n_checks++; n_fail++;
      $display("FAIL wait_events: got %0d frame ends required %0d", fd_cyc_q.size() + to_cyc_q.size(), target);
    end
  endtask

  task automatic wait_sending(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (is_sending) break;
    end
    if (i == budget) begin
      n_checks++; n_fail++;
      $display("FAIL wait_sending: got is_sending=0 required 1 within %0d cycles", budget);
    end
  endtask

  typedef struct {
    logic [31:0] msg;
    sf_t         sf;
    int          stub;
    bit          exp_elen;
    bit          exp_to;
  } vec_t;

  vec_t vecs[9];
  int   exp_id = 0;

  initial begin
    bit acc;
    int nacc, b_send, b_fd, b_to, b_elen, b_seed;
    logic [31:0] exp_msgs[6];

    vecs[0] = '{32'hA5A5_0001, SF2,  128,  1'b0, 1'b0};
    vecs[1] = '{32'hA5A5_0002, SF4,  256,  1'b0, 1'b0};
    vecs[2] = '{32'hA5A5_0003, SF8,  512,  1'b0, 1'b0};
    vecs[3] = '{32'hA5A5_0004, SF16, 1024, 1'b0, 1'b0};
    vecs[4] = '{32'hBAD0_0100, SF2,  100,  1'b1, 1'b0};
    vecs[5] = '{32'hBAD0_0128, SF4,  128,  1'b1, 1'b0};
    vecs[6] = '{32'hBAD0_0129, SF2,  129,  1'b1, 1'b0};
    vecs[7] = '{32'h7100_0000, SF8,  0,    1'b0, 1'b1};
    vecs[8] = '{32'h5A70_5000, SF16, 5000, 1'b1, 1'b0};

    // Reset values
    #12;
    check("rst_ready", 32'(msg_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_send", 32'(tx_send), 32'd0);
    check("rst_msg_id", 32'(msg_id), 32'd0);
    check("rst_tx_msg", tx_msg, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_send", 32'(send_cyc_q.size()), 32'd0);

    // Single frames from an idle scheduler
    for (int i = 0; i < 9; i++) begin
      stub_len = vecs[i].stub;
      b_send = send_cyc_q.size(); b_fd = fd_cyc_q.size(); b_to = to_cyc_q.size(); b_elen = elen_cnt;
      push(vecs[i].msg, vecs[i].sf, acc);
      wait_events(b_fd + b_to + 1, 6000);
      repeat (3) @(negedge clk);
      if (!vecs[i].exp_to) exp_id++;
      check("vec_sends", 32'(send_cyc_q.size()), 32'(b_send + 1));
      if (send_cyc_q.size() > b_send) begin
        check("vec_msg", send_msg_q[b_send], vecs[i].msg);
        check("vec_sf", 32'(send_sf_q[b_send]), 32'(vecs[i].sf));
        check("vec_latency", 32'(send_cyc_q[b_send] - push_cyc), 32'd2);
        if (vecs[i].exp_to && to_cyc_q.size() > b_to)
          check("vec_timeout_delay", 32'(to_cyc_q[b_to] - send_cyc_q[b_send]), 32'd5);
      end
      check("vec_err_len", 32'(elen_cnt - b_elen), 32'(vecs[i].exp_elen));
      check("vec_err_timeout", 32'(to_cyc_q.size() - b_to), 32'(vecs[i].exp_to));
      check("vec_msg_id", 32'(msg_id), 32'(exp_id));
      check("vec_idle_busy", 32'(busy), 32'd0);
    end

    // Seed and message in the same idle cycle: seed goes first
    stub_len = 128;
    b_send = send_cyc_q.size(); b_seed = seed_cyc_q.size(); b_fd = fd_cyc_q.size(); b_to = to_cyc_q.size();
    @(negedge clk);
    seed_valid = 1'b1; seed = 32'hDEAD_BEEF;
    msg_valid = 1'b1; msg = 32'h1234_5678; sf = SF2;
    @(posedge clk); #1;
    push_cyc = cyc; seed_valid = 1'b0; msg_valid = 1'b0;
    wait_events(b_fd + b_to + 1, 600);
    exp_id++;
    check("seed_count", 32'(seed_cyc_q.size()), 32'(b_seed + 1));
    if (seed_cyc_q.size() > b_seed) begin
      check("seed_value", seed_val_q[b_seed], 32'hDEAD_BEEF);
      check("seed_latency", 32'(seed_cyc_q[b_seed] - push_cyc), 32'd2);
    end
    if (send_cyc_q.size() > b_send) begin
      check("seed_then_msg", send_msg_q[b_send], 32'h1234_5678);
      check("seed_then_latency", 32'(send_cyc_q[b_send] - push_cyc), 32'd4);
    end

    // Seeds during a frame wait for its end; the last value wins
    repeat (3) @(negedge clk);
    b_seed = seed_cyc_q.size(); b_fd = fd_cyc_q.size(); b_to = to_cyc_q.size();
    push(32'h0000_5EED, SF2, acc);
    wait_sending(20);
    @(negedge clk); seed_valid = 1'b1; seed = 32'h1111_1111;
    @(negedge clk); seed_valid = 1'b0;
    repeat (3) @(negedge clk); seed_valid = 1'b1; seed = 32'h2222_2222;
    @(negedge clk); seed_valid = 1'b0;
    check("seed_held_in_frame", 32'(seed_cyc_q.size()), 32'(b_seed));
    wait_events(b_fd + b_to + 1, 600);
    repeat (5) @(negedge clk);
    exp_id++;
    check("seed_after_count", 32'(seed_cyc_q.size()), 32'(b_seed + 1));
    if (seed_cyc_q.size() > b_seed && fd_cyc_q.size() > b_fd) begin
      check("seed_last_wins", seed_val_q[b_seed], 32'h2222_2222);
      check("seed_after_frame", 32'(seed_cyc_q[b_seed] - fd_cyc_q[b_fd]), 32'd3);
    end

    // Back-to-back frames across all spreading factors
    stub_len = -1;
    b_send = send_cyc_q.size(); b_fd = fd_cyc_q.size(); b_to = to_cyc_q.size(); b_elen = elen_cnt;
    push(32'hC0DE_0002, SF2, acc);
    push(32'hC0DE_0004, SF4, acc);
    push(32'hC0DE_0008, SF8, acc);
    push(32'hC0DE_0016, SF16, acc);
    wait_events(b_fd + b_to + 4, 5000);
    exp_id += 4;
    check("b2b_err_len", 32'(elen_cnt - b_elen), 32'd0);
    check("b2b_msg_id", 32'(msg_id), 32'(exp_id));
    for (int i = 0; i < 3; i++)
      if (send_cyc_q.size() > b_send + i + 1 && fd_cyc_q.size() > b_fd + i)
        check("b2b_spacing", 32'(send_cyc_q[b_send + i + 1] - fd_cyc_q[b_fd + i]), 32'd3);

    // Full queue, rejected push, and a push coinciding with a pop
    repeat (3) @(negedge clk);
    b_send = send_cyc_q.size(); b_fd = fd_cyc_q.size(); b_to = to_cyc_q.size();
    exp_msgs = '{32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 32'hF000_0003, 32'hF000_0004, 32'hF000_0005};
    push(exp_msgs[0], SF2, acc);
    wait_sending(20);
    nacc = 0;
    for (int i = 1; i <= 4; i++) begin push(exp_msgs[i], SF2, acc); nacc += int'(acc); end
    check("full_accepted", 32'(nacc), 32'd4);
    push(exp_msgs[5], SF2, acc);
    check("full_rejected", 32'(acc), 32'd0);
    check("full_level", 32'(level), 32'd4);
    check("full_ready", 32'(msg_ready), 32'd0);
    wait_events(b_fd + b_to + 2, 600);
    @(negedge clk);
    check("pushpop_level_before", 32'(level), 32'd3);
    msg_valid = 1'b1; msg = exp_msgs[5]; sf = SF2;
    @(posedge clk); #1; msg_valid = 1'b0;
    check("pushpop_level_after", 32'(level), 32'd3);
    wait_events(b_fd + b_to + 6, 2000);
    exp_id += 6;
    check("full_sends", 32'(send_cyc_q.size()), 32'(b_send + 6));
    for (int i = 0; i < 6; i++)
      if (send_cyc_q.size() > b_send + i) check("full_order", send_msg_q[b_send + i], exp_msgs[i]);
    check("full_msg_id", 32'(msg_id), 32'(exp_id));
    check("full_level_end", 32'(level), 32'd0);
    check("len_err_with_done", 32'(elen_orphan), 32'd0);

    // Reset mid-frame with three messages queued
    repeat (3) @(negedge clk);
    push(32'hEEEE_0000, SF16, acc);
    wait_sending(20);
    push(32'hEEEE_0001, SF2, acc);
    push(32'hEEEE_0002, SF2, acc);
    push(32'hEEEE_0003, SF2, acc);
    repeat (20) @(negedge clk);
    b_send = send_cyc_q.size(); b_fd = fd_cyc_q.size(); b_to = to_cyc_q.size(); b_elen = elen_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_ready", 32'(msg_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_msg_id", 32'(msg_id), 32'd0);
    check("mid_rst_tx_msg", tx_msg, 32'd0);
    check("mid_rst_tx_sf", 32'(tx_sf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (1100) @(negedge clk);
    check("post_rst_sends", 32'(send_cyc_q.size() - b_send), 32'd0);
    check("post_rst_frames", 32'(fd_cyc_q.size() - b_fd), 32'd0);
    check("post_rst_errs", 32'(elen_cnt - b_elen + to_cyc_q.size() - b_to), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Front-end sequencer for the DCSK transmitter (`tx`). It queues 32-bit messages with their spreading factors from an upstream valid/ready source and loads the chaotic-generator seed on request. It issues one `i_send` start pulse per message to `tx`, then waits for the frame to complete. It also polices each frame's length against the spreading factor and inserts a programmable silence gap between frames.

## Interface
- `FIFO_DEPTH`, default 4: message queue depth; power of two, at least 2.
- `GAP_CYCLES`, default 0: idle cycles forced between the end of one frame and the next send pulse.
- `START_TIMEOUT`, default 4: cycles allowed after a send pulse for `i_tx_is_sending` to rise.
- `i_clk`  in  1  single clock; all logic is rising-edge.
- `i_arst_n`  in  1  reset, asynchronous, active-low.
- `i_msg_valid`  in  1  upstream message valid.
- `o_msg_ready`  out  1  queue not full.
- `i_msg`  in  32  message payload.
- `i_sf`  in  sf_t (2)  spreading factor: SF2=0, SF4=1, SF8=2, SF16=3.
- `i_seed_valid`  in  1  seed load request (single-cycle pulse).
- `i_seed`  in  32  seed value, sampled with `i_seed_valid`.
- `o_tx_seed`  out  32  to `tx.i_seed`.
- `o_tx_load_seed`  out  1  to `tx.i_load_seed`; one-cycle pulse.
- `o_tx_send`  out  1  to `tx.i_send`; one-cycle pulse.
- `o_tx_msg`  out  32  to `tx.i_msg`; held from send until the frame ends.
- `o_tx_sf`  out  sf_t  to `tx.i_sf`; held like `o_tx_msg`.
- `i_tx_is_sending`  in  1  from `tx.o_is_sending`.
- `o_busy`  out  1  state not IDLE, or queue not empty.
- `o_level`  out  $clog2(FIFO_DEPTH)+1  queue occupancy.
- `o_frame_done`  out  1  one-cycle pulse at each frame end.
- `o_err_len`  out  1  one-cycle pulse, frame length mismatch.
- `o_err_timeout`  out  1  one-cycle pulse, `tx` never started.
- `o_msg_id`  out  16  count of completed frames; wraps at 2^16.

## Operation
- **Queue:** push on `i_msg_valid && o_msg_ready`, storing {msg, sf}. `o_msg_ready = (o_level != FIFO_DEPTH)`. Pushing while full is impossible by construction.
- **Seed:** the seed request is latched into a pending flag and a seed register, even while busy. A second request before service overwrites the value (last wins).
- **State machine:**
  - IDLE:
    - If seed is pending, go to SEED. Seed has priority over a queued message.
    - Else if the queue is not empty, pop, register {msg, sf} onto `o_tx_msg`/`o_tx_sf`, and go to SEND.
  - SEED: `o_tx_load_seed=1` for one cycle; clear the pending flag; go to IDLE.
  - SEND: `o_tx_send=1` for one cycle; clear the timer; go to WAIT_START.
  - WAIT_START:
    - If `i_tx_is_sending` is sampled 1, set the length counter to 1 and go to SENDING.
    - Otherwise, after START_TIMEOUT sampled-0 cycles, pulse `o_err_timeout` and go to GAP.
  - SENDING:
    - While `i_tx_is_sending` is 1, increment the length counter.
    - On a sampled 0:
      - pulse `o_frame_done` and increment `o_msg_id`;
      - if the counter differs from FRAME_LEN(sf), also pulse `o_err_len`;
      - go to GAP.
  - GAP: wait GAP_CYCLES (zero means pass straight through in one cycle), then go to IDLE.
- **Frame length:** FRAME_LEN(sf) = 64 << (sf+1), giving 128/256/512/1024 cycles for SF2..SF16.
  - The length counter is 12 bits and saturates at 4095.
  - A saturated count is always a length error.
- `o_tx_msg`/`o_tx_sf` change only when popping in IDLE.
- A seed load never interrupts a frame. It is serviced at the next IDLE.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - state=IDLE, queue empty, seed flag cleared;
  - all outputs 0, `o_msg_ready` = 1, `o_msg_id` = 0.
- A reset mid-frame flushes the queue and the pending seed with no error pulse.
- Latency with an empty queue in IDLE:
  - push at edge k, pop at edge k+1;
  - `o_tx_send` is high in the cycle after edge k+2.
- Back-to-back frames with GAP_CYCLES=0: the next send pulse comes 3 cycles after `i_tx_is_sending` is sampled low (GAP, IDLE, SEND).
- Simultaneous push and pop: both occur, and `o_level` is unchanged.
- Pushing while full has no effect, since ready is low.
- Pointers wrap modulo FIFO_DEPTH.
- A seed request arriving in the same cycle IDLE pops a message is serviced after that frame.

## Structure
- Add `tx_sched_state_t` (IDLE, SEED, SEND, WAIT_START, SENDING, GAP) to `modem_pkg`.
- Add `function frame_len(sf_t)` to `spreading_factors_pkg`, where `sf_t` already lives.
- Sub-module `sync_fifo`, parameterised by width (34) and depth, with a level output, full/empty flags and async reset.
- Top-level integration: `tx_scheduler` → `tx_if` signals → `tx`.

## Test plan
- **Reset state:** assert reset mid-SENDING with 3 messages queued → all outputs 0, `o_level`=0, `o_msg_ready`=1; after release, no `o_tx_send` without new input.
- **Seed priority:** seed pulse 0xDEADBEEF plus push {0x12345678, SF2} in the same cycle while idle → `o_tx_load_seed` with `o_tx_seed`=0xDEADBEEF, then `o_tx_send` with `o_tx_msg`=0x12345678; the received frame demodulates to 0x12345678.
- **Full queue:** push 5 messages with FIFO_DEPTH=4 while `tx` is busy → `o_msg_ready`=0 at `o_level`=4; all accepted messages are sent in order; `o_msg_id` ends at the accepted count.
- **All spreading factors:** one message per SF with GAP_CYCLES=0 → `i_tx_is_sending` high for 128/256/512/1024 cycles; no `o_err_len`; sends are 3 cycles apart.
- **Length error:** a stub `tx` drops `o_is_sending` after 100 cycles at SF2 → `o_err_len` pulses once together with `o_frame_done`.
- **Start timeout:** a stub `tx` never raises `o_is_sending`, START_TIMEOUT=4 → `o_err_timeout` 5 cycles after the send pulse; the next queued message is still sent.
